// File: rtl/i2c_txn_sequencer_if.sv
// Command/response channel between the transaction sequencer and the I2C byte engine.
interface i2c_txn_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_mack;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata, cmd_mack,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata, cmd_mack,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack
    );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Round-robin front end for the I2C byte engine: latches one requester's register
// access descriptor and walks the engine through the write or repeated-start read.
module i2c_txn_sequencer #(
    parameter  int NUM_REQ = 2,
    parameter  int MAX_LEN = 4,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_rw,
    input  logic [7*NUM_REQ-1:0]           req_dev,
    input  logic [8*NUM_REQ-1:0]           req_reg,
    input  logic [LEN_W*NUM_REQ-1:0]       req_len,
    input  logic [8*MAX_LEN*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           err,
    output logic [8*MAX_LEN-1:0]           rdata,
    i2c_txn_sequencer_if.master            eng
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BI_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_READ = 3'd2,
                           OP_STOP  = 3'd3, OP_RSTART = 3'd4;

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [2:0] {P_START, P_DEVW, P_REG, P_DATA, P_RSTART, P_DEVR, P_READ, P_STOP} phase_t;

    typedef struct packed {
        logic                      rw;
        logic [6:0]                dev;
        logic [7:0]                ra;
        logic [LEN_W-1:0]          len;
        logic [MAX_LEN-1:0][7:0]   wdata;
    } desc_t;

    logic [NUM_REQ-1:0][6:0]             dev_v;
    logic [NUM_REQ-1:0][7:0]             reg_v;
    logic [NUM_REQ-1:0][LEN_W-1:0]       len_v;
    logic [NUM_REQ-1:0][MAX_LEN-1:0][7:0] wd_v;
    assign dev_v = req_dev;
    assign reg_v = req_reg;
    assign len_v = req_len;
    assign wd_v  = req_wdata;

    state_t                  state, state_nxt;
    phase_t                  phase, phase_nxt;
    logic [LEN_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        rr_ptr, win_idx;
    logic                    win_vld;
    desc_t                   d, win_desc;
    logic [MAX_LEN-1:0][7:0] rd_r;
    logic [BI_W-1:0]         cnt_b;
    logic                    last, nk;

    assign cnt_b = cnt[BI_W-1:0];
    assign last  = (cnt + LEN_W'(1)) == d.len;
    assign rdata = rd_r;
    // Only WRITE responses carry a meaningful slave ACK.
    assign nk    = eng.rsp_nack && (phase inside {P_DEVW, P_REG, P_DATA, P_DEVR});

    // Round-robin search starting one past the last winner.
    always_comb begin
        int c;
        c        = 0;
        win_vld  = 1'b0;
        win_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!win_vld && req[IDX_W'(c)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(c);
            end
        end
        win_desc.rw    = req_rw[win_idx];
        win_desc.dev   = dev_v[win_idx];
        win_desc.ra    = reg_v[win_idx];
        win_desc.len   = (len_v[win_idx] > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_v[win_idx];
        win_desc.wdata = wd_v[win_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            phase <= P_START;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (win_vld) begin
                state_nxt = ISSUE;
                phase_nxt = P_START;
                cnt_nxt   = '0;
            end
            ARB:   state_nxt = ISSUE;
            ISSUE: if (eng.cmd_ready) state_nxt = WAIT;
            WAIT: if (eng.rsp_valid) begin
                state_nxt = (phase == P_STOP) ? DONE : ISSUE;
                if (nk) phase_nxt = P_STOP;
                else begin
                    case (phase)
                        P_START:  phase_nxt = P_DEVW;
                        P_DEVW:   phase_nxt = P_REG;
                        P_REG:    phase_nxt = (d.len == '0) ? P_STOP : (d.rw ? P_RSTART : P_DATA);
                        P_RSTART: phase_nxt = P_DEVR;
                        P_DEVR:   phase_nxt = P_READ;
                        P_DATA, P_READ: begin
                            if (last) phase_nxt = P_STOP;
                            else      cnt_nxt   = cnt + LEN_W'(1);
                        end
                        default:  phase_nxt = P_STOP;
                    endcase
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eng.cmd_valid = 1'b0;
        eng.cmd_op    = OP_START;
        eng.cmd_wdata = '0;
        eng.cmd_mack  = 1'b0;
        done          = '0;
        if (state == ISSUE) begin
            eng.cmd_valid = 1'b1;
            case (phase)
                P_START:  eng.cmd_op = OP_START;
                P_DEVW:   begin eng.cmd_op = OP_WRITE; eng.cmd_wdata = {d.dev, 1'b0}; end
                P_REG:    begin eng.cmd_op = OP_WRITE; eng.cmd_wdata = d.ra; end
                P_DATA:   begin eng.cmd_op = OP_WRITE; eng.cmd_wdata = d.wdata[cnt_b]; end
                P_RSTART: eng.cmd_op = OP_RSTART;
                P_DEVR:   begin eng.cmd_op = OP_WRITE; eng.cmd_wdata = {d.dev, 1'b1}; end
                P_READ:   begin eng.cmd_op = OP_READ; eng.cmd_mack = last; end
                default:  eng.cmd_op = OP_STOP;
            endcase
        end
        if (state == DONE) done = grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
            d      <= '0;
            err    <= 1'b0;
            rd_r   <= '0;
        end else if (state == IDLE && win_vld) begin
            grant  <= NUM_REQ'(1) << win_idx;
            rr_ptr <= win_idx;
            d      <= win_desc;
            err    <= 1'b0;
            rd_r   <= '0;
        end else if (state == WAIT && eng.rsp_valid) begin
            if (phase == P_READ) rd_r[cnt_b] <= eng.rsp_rdata;
            if (nk) err <= 1'b1;
        end else if (state == DONE) begin
            grant <= '0;
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Scoreboard bench: a behavioural byte engine checks every command against the
// expected stream and a completion monitor checks done/err/rdata.
module tb_i2c_txn_sequencer;
    localparam int NUM_REQ = 2, MAX_LEN = 4, LEN_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]           req = '0, req_rw = '0;
    logic [7*NUM_REQ-1:0]         req_dev = '0;
    logic [8*NUM_REQ-1:0]         req_reg = '0;
    logic [LEN_W*NUM_REQ-1:0]     req_len = '0;
    logic [8*MAX_LEN*NUM_REQ-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]           grant, done;
    logic                         err;
    logic [8*MAX_LEN-1:0]         rdata;

    i2c_txn_sequencer_if bus();

    i2c_txn_sequencer #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_dev(req_dev),
        .req_reg(req_reg), .req_len(req_len), .req_wdata(req_wdata),
        .grant(grant), .done(done), .err(err), .rdata(rdata), .eng(bus)
    );

    typedef struct {int g; bit e; logic [31:0] rd;} done_t;

    int          n_cmp = 0, n_bad = 0, n_done = 0, n_rd_hs = 0;
    int          stall = 0, lat = 1, nack_at = -1;
    bit          noise_nack = 1'b0;
    int          exp_cmd_q[$];
    done_t       exp_done_q[$];
    logic [7:0]  rd_q[$];

    function automatic int enc(input logic [2:0] op, input logic mk, input logic [7:0] wd);
        return int'(op) * 512 + ((op == 3'd2) ? int'(mk) : 0) * 256 + ((op == 3'd1) ? int'(wd) : 0);
    endfunction

    // Reference sequence for one transaction; pushes commands, read bytes and completion.
    task automatic expect_txn(input int g, input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                              input int len, input logic [31:0] wd, input int nak, input logic [31:0] rd);
        int n, wi;
        bit nk;
        logic [31:0] rx;
        done_t dd;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        wi = 0; nk = 0; rx = '0;
        exp_cmd_q.push_back(enc(3'd0, 1'b0, 8'h00));
        exp_cmd_q.push_back(enc(3'd1, 1'b0, {dev, 1'b0}));
        if (wi++ == nak) nk = 1;
        if (!nk) begin
            exp_cmd_q.push_back(enc(3'd1, 1'b0, rg));
            if (wi++ == nak) nk = 1;
        end
        if (!nk && n > 0) begin
            if (!rw) begin
                for (int i = 0; i < n && !nk; i++) begin
                    exp_cmd_q.push_back(enc(3'd1, 1'b0, wd[8*i +: 8]));
                    if (wi++ == nak) nk = 1;
                end
            end else begin
                exp_cmd_q.push_back(enc(3'd4, 1'b0, 8'h00));
                exp_cmd_q.push_back(enc(3'd1, 1'b0, {dev, 1'b1}));
                if (wi++ == nak) nk = 1;
                if (!nk) begin
                    for (int i = 0; i < n; i++) begin
                        exp_cmd_q.push_back(enc(3'd2, (i == n - 1), 8'h00));
                        rx[8*i +: 8] = rd[8*i +: 8];
                        rd_q.push_back(rd[8*i +: 8]);
                    end
                end
            end
        end
        exp_cmd_q.push_back(enc(3'd3, 1'b0, 8'h00));
        dd.g = g; dd.e = nk; dd.rd = rx;
        exp_done_q.push_back(dd);
    endtask

    task automatic set_desc(input int g, input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [2:0] len, input logic [31:0] wd);
        req_rw[g] = rw;
        req_dev[7*g +: 7] = dev;
        req_reg[8*g +: 8] = rg;
        req_len[3*g +: 3] = len;
        req_wdata[32*g +: 32] = wd;
    endtask

    task automatic wait_dones(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (n_done >= target) begin ok = 1'b1; break; end
        end
    endtask

    // Behavioural engine: stall, accept, respond after lat cycles.
    initial begin
        int st, left, w_idx, cap, key;
        logic [2:0] cop;
        logic [7:0] cwd;
        logic cmk;
        st = 0; left = 0; w_idx = 0; cop = '0; cwd = '0; cmk = 1'b0;
        bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0; bus.rsp_nack = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            if (!rst_n) begin
                st = 0;
                bus.cmd_ready = 1'b0;
            end else begin
                case (st)
                    0: if (bus.cmd_valid) begin
                        cop = bus.cmd_op; cwd = bus.cmd_wdata; cmk = bus.cmd_mack;
                        cap = enc(cop, cmk, cwd);
                        n_cmp++;
                        if (exp_cmd_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL cmd_unexpected: got op=%0d wdata=%h mack=%0d, expected no command", cop, cwd, cmk);
                        end else begin
                            key = exp_cmd_q.pop_front();
                            if (cap !== key) begin
                                n_bad++;
                                $display("FAIL cmd_stream: got op=%0d wdata=%h mack=%0d, expected op=%0d wdata=%h mack=%0d",
                                         cop, cwd, cmk, key / 512, key % 256, (key / 256) % 2);
                            end
                        end
                        if (cop == 3'd0) w_idx = 0;
                        left = stall;
                        if (left == 0) begin bus.cmd_ready = 1'b1; st = 2; end
                        else st = 1;
                    end
                    1: begin
                        n_cmp++;
                        if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== cop || bus.cmd_wdata !== cwd || bus.cmd_mack !== cmk) begin
                            n_bad++;
                            $display("FAIL cmd_stable: got v=%0d op=%0d wdata=%h mack=%0d, expected v=1 op=%0d wdata=%h mack=%0d",
                                     bus.cmd_valid, bus.cmd_op, bus.cmd_wdata, bus.cmd_mack, cop, cwd, cmk);
                        end
                        left--;
                        if (left == 0) begin bus.cmd_ready = 1'b1; st = 2; end
                    end
                    2: begin
                        bus.cmd_ready = 1'b0;
                        n_cmp++;
                        if (bus.cmd_valid !== 1'b0) begin
                            n_bad++;
                            $display("FAIL cmd_valid_after_hs: got %0d expected 0", bus.cmd_valid);
                        end
                        if (cop == 3'd2) n_rd_hs++;
                        left = lat;
                        st = 3;
                    end
                    default: begin
                        if (left > 0) left--;
                        else begin
                            bus.rsp_valid = 1'b1;
                            bus.rsp_nack  = (cop == 3'd1) ? (w_idx == nack_at) : noise_nack;
                            bus.rsp_rdata = 8'h00;
                            if (cop == 3'd2 && rd_q.size() > 0) bus.rsp_rdata = rd_q.pop_front();
                            if (cop == 3'd1) w_idx++;
                            st = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Completion and grant monitor.
    initial begin
        logic [NUM_REQ-1:0] prev_g;
        done_t dd;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (rst_n && done !== '0) begin
                n_cmp++;
                if (exp_done_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL done_unexpected: got done=%b, expected none", done);
                end else begin
                    dd = exp_done_q.pop_front();
                    if (done !== (NUM_REQ'(1) << dd.g) || err !== dd.e || rdata !== dd.rd) begin
                        n_bad++;
                        $display("FAIL done_status: got done=%b err=%0d rdata=%h, expected done=%b err=%0d rdata=%h",
                                 done, err, rdata, NUM_REQ'(1) << dd.g, dd.e, dd.rd);
                    end
                end
                n_done++;
            end
            if (grant !== prev_g) begin
                n_cmp++;
                if ($countones(grant) > 1 || (prev_g !== '0 && grant !== '0)) begin
                    n_bad++;
                    $display("FAIL grant_change: got %b after %b, expected one-hot from/to zero", grant, prev_g);
                end
            end
            prev_g = grant;
        end
    end

    task automatic run_one(input string nm, input int g, input bit rw, input logic [6:0] dev,
                           input logic [7:0] rg, input int len, input logic [31:0] wd,
                           input logic [31:0] rd, input bit exp_err, input logic [31:0] exp_rd);
        bit ok;
        int base;
        base = n_done;
        expect_txn(g, rw, dev, rg, len, wd, nack_at, rd);
        set_desc(g, rw, dev, rg, 3'(len), wd);
        req[g] = 1'b1;
        wait_dones(base + 1, ok);
        req[g] = 1'b0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s_timeout: got %0d dones, expected %0d", nm, n_done - base, 1); end
        n_cmp++;
        if (grant !== '0 || err !== exp_err || rdata !== exp_rd) begin
            n_bad++;
            $display("FAIL %s_after: got grant=%b err=%0d rdata=%h, expected grant=0 err=%0d rdata=%h",
                     nm, grant, err, rdata, exp_err, exp_rd);
        end
        n_cmp++;
        if (exp_cmd_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_cmds_left: got %0d outstanding, expected 0", nm, exp_cmd_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (grant !== '0 || done !== '0 || err !== 1'b0 || rdata !== '0 || bus.cmd_valid !== 1'b0 ||
            bus.cmd_op !== 3'd0 || bus.cmd_wdata !== 8'h00 || bus.cmd_mack !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vals: got grant=%b done=%b err=%0d rdata=%h v=%0d op=%0d wd=%h mk=%0d, expected all 0",
                     grant, done, err, rdata, bus.cmd_valid, bus.cmd_op, bus.cmd_wdata, bus.cmd_mack);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (grant !== '0 || bus.cmd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got grant=%b v=%0d, expected 0 0", grant, bus.cmd_valid);
        end
    endtask

    task automatic test_write();
        stall = 0; lat = 1; nack_at = -1; noise_nack = 0;
        run_one("write", 0, 1'b0, 7'h50, 8'h10, 2, 32'h0000_55AC, '0, 1'b0, 32'h0);
    endtask

    task automatic test_nack();
        nack_at = 0;
        run_one("nack", 0, 1'b1, 7'h50, 8'h44, 3, '0, 32'h00_998877, 1'b1, 32'h0);
        nack_at = -1;
    endtask

    task automatic test_read();
        noise_nack = 1;
        lat = 2;
        run_one("read", 1, 1'b1, 7'h50, 8'h50, 3, '0, 32'h0033_2211, 1'b0, 32'h0033_2211);
        noise_nack = 0;
        lat = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        base = n_done;
        for (int k = 0; k < 2; k++) begin
            expect_txn(0, 1'b0, 7'h21, 8'h01, 1, 32'h5A, -1, '0);
            expect_txn(1, 1'b1, 7'h33, 8'h02, 2, '0, -1, 32'h0000_B0A0 + 32'(k));
        end
        set_desc(0, 1'b0, 7'h21, 8'h01, 3'd1, 32'h5A);
        set_desc(1, 1'b1, 7'h33, 8'h02, 3'd2, '0);
        req = 2'b11;
        wait_dones(base + 4, ok);
        req = 2'b00;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got %0d dones, expected 4", n_done - base); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_done_q.size() != 0 || exp_cmd_q.size() != 0 || grant !== '0) begin
            n_bad++;
            $display("FAIL b2b_drain: got done_q=%0d cmd_q=%0d grant=%b, expected 0 0 0",
                     exp_done_q.size(), exp_cmd_q.size(), grant);
        end
    endtask

    task automatic test_stall();
        stall = 5;
        run_one("stall", 0, 1'b0, 7'h68, 8'hA5, 3, 32'h0003_0201, '0, 1'b0, 32'h0);
        stall = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        expect_txn(1, 1'b1, 7'h50, 8'h20, 4, '0, -1, 32'hDD_CC_BB_AA);
        set_desc(1, 1'b1, 7'h50, 8'h20, 3'd4, '0);
        req[1] = 1'b1;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (n_rd_hs >= 2) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rstmid_no_read: got %0d reads, expected 2", n_rd_hs); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (grant !== '0 || done !== '0 || err !== 1'b0 || rdata !== '0 || bus.cmd_valid !== 1'b0 ||
            bus.cmd_op !== 3'd0 || bus.cmd_wdata !== 8'h00 || bus.cmd_mack !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async: got grant=%b done=%b err=%0d rdata=%h v=%0d op=%0d wd=%h mk=%0d, expected all 0",
                     grant, done, err, rdata, bus.cmd_valid, bus.cmd_op, bus.cmd_wdata, bus.cmd_mack);
        end
        exp_cmd_q.delete(); exp_done_q.delete(); rd_q.delete();
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        // After reset requester 0 has priority; both len-0 accesses are pointer-set only.
        base = n_done;
        expect_txn(0, 1'b0, 7'h3C, 8'h7E, 0, 32'hFFFF_FFFF, -1, '0);
        expect_txn(1, 1'b1, 7'h12, 8'h34, 0, '0, -1, '0);
        set_desc(0, 1'b0, 7'h3C, 8'h7E, 3'd0, 32'hFFFF_FFFF);
        set_desc(1, 1'b1, 7'h12, 8'h34, 3'd0, '0);
        #1 req = 2'b11;
        wait_dones(base + 2, ok);
        req = '0;
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL len0_timeout: got %0d dones, expected 2", n_done - base); end
        n_cmp++;
        if (err !== 1'b0 || rdata !== '0 || exp_cmd_q.size() != 0) begin
            n_bad++;
            $display("FAIL len0_after: got err=%0d rdata=%h cmd_q=%0d, expected 0 0 0", err, rdata, exp_cmd_q.size());
        end
    endtask

    task automatic test_clamp_nack_data();
        run_one("clamp", 1, 1'b0, 7'h0F, 8'hC3, 7, 32'h4433_2211, '0, 1'b0, 32'h0);
        nack_at = 3;
        run_one("nack_data", 0, 1'b0, 7'h2A, 8'h99, 3, 32'h0077_6655, '0, 1'b1, 32'h0);
        nack_at = -1;
    endtask

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got no finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_nack();
        test_read();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_clamp_nack_data();
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Transaction-level controller that sits in front of the I2C master bit/byte engine and shares it between several requesters. It arbitrates round-robin among requesters and latches the winner's register-access descriptor. It then sequences the engine through the byte-level command stream for a register write or a register read (with repeated start), and returns read data, completion and NACK status to the granted requester.

## Interface
- NUM_REQ, 2: number of requesters (1..8).
- MAX_LEN, 4: maximum data bytes per transaction (1..8); LEN_W = $clog2(MAX_LEN+1).
- clk  in  1  system clock; the engine runs on the same clock.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- req  in  NUM_REQ  per-requester transaction request; held high until that requester's done pulse.
- req_rw  in  NUM_REQ  per requester: 0 = write, 1 = read.
- req_dev  in  7*NUM_REQ  7-bit device address per requester.
- req_reg  in  8*NUM_REQ  register address per requester.
- req_len  in  LEN_W*NUM_REQ  data byte count per requester.
- req_wdata  in  8*MAX_LEN*NUM_REQ  write bytes; byte i is at [8i+:8] within each requester's slice.
- grant  out  NUM_REQ  one-hot; the active requester.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- err  out  1  NACK status of the last transaction; valid with done.
- rdata  out  8*MAX_LEN  read bytes; byte i at [8i+:8]; unread bytes are 0.
- cmd_valid  out  1  command to engine.
- cmd_ready  in  1  engine accepts the command when cmd_valid && cmd_ready.
- cmd_op  out  3  0 START, 1 WRITE, 2 READ, 3 STOP, 4 RSTART.
- cmd_wdata  out  8  byte to send for WRITE.
- cmd_mack  out  1  master ACK for READ: 0 = ACK, 1 = NACK.
- rsp_valid  in  1  one-cycle pulse; the engine has finished the accepted command.
- rsp_rdata  in  8  received byte; valid with rsp_valid after READ.
- rsp_nack  in  1  slave NACKed; valid with rsp_valid after WRITE.

## Operation
- States: IDLE, ARB, ISSUE, WAIT, DONE.
  - ISSUE holds cmd_valid until the handshake.
  - WAIT waits for rsp_valid.
  - A step counter selects the next command.
- Write sequence: START; WRITE {dev,0}; WRITE reg; WRITE data[0..len-1]; STOP.
- Read sequence: START; WRITE {dev,0}; WRITE reg; RSTART; WRITE {dev,1}; READ ×len; STOP.
  - cmd_mack = 0 on every READ except the last, which uses cmd_mack = 1.
- len = 0, for both rw values: pointer-set only (START, dev, reg, STOP); no error.
- len > MAX_LEN is clamped to MAX_LEN.
- Any WRITE response with rsp_nack = 1:
  - skip the remaining commands and issue STOP;
  - err = 1;
  - rdata bytes not yet received stay 0.
- rsp_nack is ignored for START, STOP, RSTART and READ.
- Arbitration happens in IDLE only, and is round-robin.
  - Search starts at last-granted+1 (mod NUM_REQ).
  - After reset, requester 0 has highest priority.
- The descriptor is latched at grant; requester inputs are not sampled again until the next arbitration.
- rsp_valid outside WAIT is ignored.
- A req dropped while granted is ignored; the transaction completes normally.

## Timing
- Reset values:
  - grant = 0, done = 0, err = 0, rdata = 0;
  - cmd_valid = 0, cmd_op = 0, cmd_wdata = 0, cmd_mack = 0;
  - state = IDLE, round-robin pointer = NUM_REQ-1.
- rst_n asserted mid-transaction: all outputs go to reset values immediately. The engine shares rst_n, so the bus is released by the engine.
- Edge k in IDLE with any req high:
  - grant is registered at edge k;
  - cmd_valid with START is visible from edge k (ARB is combinational with the IDLE→ISSUE transition).
- cmd_valid, cmd_op, cmd_wdata and cmd_mack are stable while cmd_valid && !cmd_ready.
- The handshake cycle moves to WAIT; cmd_valid = 0 the next cycle.
- rsp_valid at edge m:
  - next cmd_valid is high after edge m;
  - for a READ, rsp_rdata is captured into rdata at edge m.
- After the STOP response: DONE for exactly one cycle, with done[g] = 1, err and rdata valid.
- grant drops after DONE; err and rdata hold until the next grant clears them.
- Minimum one IDLE cycle between transactions; the same requester may win again only if no other req is high.
- Overhead: one cycle per command beyond engine latency, plus 1 (DONE) + 1 (IDLE).

## Test plan
- Write, req0, dev 0x50, reg 0x10, len 2, data 0xAC,0x55, engine always ACKs:
  - command stream START, W 0xA0, W 0x10, W 0xAC, W 0x55, STOP;
  - done[0] pulse, err = 0.
- Read, req1, dev 0x50, reg 0x50, len 3, engine returns 0x11,0x22,0x33:
  - command stream START, W 0xA0, W 0x50, RSTART, W 0xA1, R(mack 0), R(mack 0), R(mack 1), STOP;
  - rdata[23:0] = 0x332211, remaining bytes 0.
- NACK on the device-address byte of a read: next command is STOP; done pulses with err = 1, rdata = 0.
- req0 and req1 high together, repeated back to back:
  - grants alternate 0,1,0,1;
  - grant is never two-hot and never changes mid-transaction.
- cmd_ready held low 5 cycles on each command: cmd_* stay stable, with exactly one command per handshake.
- rst_n pulsed low during the READ phase:
  - all outputs go to 0 asynchronously;
  - after release, a new write to len 0 completes with START, W, W, STOP.
